pio_fifo: RTL
=============

Name: pio_fifo

Overview:
- Synchronous first-word-fall-through FIFO between the system bus and one state machine, 32-bit words, one per direction (TX: bus pushes, machine pulls; RX: machine pushes, bus pulls).
- The TX instance drives the machine's `din`/`empty`/`full` inputs and consumes its `pull` strobe. The RX instance consumes the machine's `push`/`dout`.
- Keeps a fill level and sticky overflow/underflow flags for the debug/status register.

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 4, entries per FIFO; power of two, minimum 2
- LW, 3, level width = log2(DEPTH)+1; must be 4 when FIFO_JOIN_EN is defined

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- push  in  1  write strobe, one word per cycle high
- din  in  WIDTH  write data, sampled when push is high
- pull  in  1  read strobe, already qualified by the consumer's clock enable; one word per cycle high
- dout  out  WIDTH  head word, valid whenever empty is low
- empty  out  1  no entries
- full  out  1  level == capacity
- level  out  LW  current entry count, 0..capacity
- clear_sticky  in  1  clears overflow and underflow
- overflow  out  1  sticky: push seen while full
- underflow  out  1  sticky: pull seen while empty
- join  in  1  FIFO_JOIN_EN only: doubles capacity

Behaviour:
- Storage is a register array with read pointer rp, write pointer wp and count cnt; pointers wrap modulo capacity.
- Reset (synchronous, highest priority, aborts everything else that cycle):
  - rp = wp = cnt = 0
  - empty=1, full=0, level=0, overflow=0, underflow=0
  - dout=0 (array contents not reset; dout muxed to 0 when empty)
- dout is combinational from mem[rp] (FWFT), with zero read latency. A pull in cycle N consumes the word shown on dout in cycle N; the next word appears in N+1.
- Write latency: a word pushed in cycle N is visible on dout and reflected in empty/level in cycle N+1.
- Push accepted iff push && !full. The word is stored at mem[wp] and wp advances.
- Pull accepted iff pull && !empty; rp advances.
- Simultaneous push and pull:
  - not empty, not full: both accepted, cnt unchanged
  - full: pull accepted and push rejected (full is evaluated before the pull); overflow is set
  - empty: push accepted and pull rejected; underflow is set
- cnt: +1 on push-only, −1 on pull-only, unchanged otherwise.
- Status outputs: empty = (cnt==0), full = (cnt==capacity), level = cnt. All are registered-derived, with no combinational path from push/pull.
- Rejected operations leave the pointers and array unchanged.
- Sticky flags:
  - overflow set on a rejected push; underflow set on a rejected pull.
  - Both hold until clear_sticky or reset.
  - If clear_sticky and a new error occur in the same cycle, set wins.
- Wrap-around: with DEPTH=4, after 5 pushes and 5 pulls, rp=wp=1 and data order is preserved.
- Machine pull semantics for blocking PULL: the machine holds pull high while stalled on empty; underflow is still flagged. Firmware ignores underflow on TX for blocking pulls.

Optional Feature:
- Macro: PIO_FIFO_JOIN_EN.
- Defined:
  - The array has 2*DEPTH entries and the `join` port exists.
  - join=1 gives capacity 2*DEPTH; join=0 gives capacity DEPTH (the upper half is unused).
  - Any change of join flushes: rp=wp=cnt=0 on the cycle after the change. Sticky flags are kept.
- Undefined: no `join` port; capacity is fixed at DEPTH.

Decomposition:
- Shared package (pio_pkg): PIO_WIDTH=32, PIO_FIFO_DEPTH=4, and the level width constant.
- No sub-module: pointer/count logic and the array fit one module.
- The TX and RX instances are the same module, instantiated twice per state machine at top level.

Test Plan:
1. Reset, then push 0xDEADBEEF → next cycle dout=0xDEADBEEF, empty=0, level=1; pull → next cycle empty=1, level=0.
2. Push 1,2,3,4 → full=1, level=4. Push 5 → overflow=1, level=4. Pull four times → dout sequence 1,2,3,4, then empty=1.
3. Fill to full, then assert push(9) and pull together → 1 popped, 9 not stored, overflow=1. Drain gives 2,3,4.
4. Level 2, assert push and pull together for 10 cycles with incrementing data → level stays 2 and output order is preserved across pointer wrap.
5. Pull while empty → underflow=1, pointers unchanged. clear_sticky together with another empty pull → underflow stays 1; clear_sticky alone → underflow=0.
6. PIO_FIFO_JOIN_EN defined, join=1: push 8 words → full only after the 8th, drain in order. Toggle join while holding 3 entries → next cycle level=0, empty=1.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the PIO block: word width, FIFO depth and level width.
// With PIO_FIFO_JOIN_EN defined, the level width covers the joined 2*DEPTH capacity.
package pio_pkg;
   localparam int PIO_WIDTH      = 32;
   localparam int PIO_FIFO_DEPTH = 4;
`ifdef PIO_FIFO_JOIN_EN
   localparam int PIO_FIFO_LW    = $clog2(2 * PIO_FIFO_DEPTH) + 1;
`else
   localparam int PIO_FIFO_LW    = $clog2(PIO_FIFO_DEPTH) + 1;
`endif
endpackage

// File: rtl/pio_fifo.sv
// First-word-fall-through FIFO between the bus and one state machine (used for TX and RX).
// Optional PIO_FIFO_JOIN_EN adds the fifo_join port, which doubles capacity and flushes on change.
module pio_fifo
   import pio_pkg::*;
#(
   parameter int WIDTH = PIO_WIDTH,
   parameter int DEPTH = PIO_FIFO_DEPTH,
   parameter int LW    = PIO_FIFO_LW
)(
   input  logic             clk,
   input  logic             reset,
`ifdef PIO_FIFO_JOIN_EN
   input  logic             fifo_join,
`endif
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pull,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [LW-1:0]    level,
   input  logic             clear_sticky,
   output logic             overflow,
   output logic             underflow
);

`ifdef PIO_FIFO_JOIN_EN
   localparam int ARR = 2 * DEPTH;
`else
   localparam int ARR = DEPTH;
`endif
   localparam int PW = $clog2(ARR);

   // Handshake: push/pull are single-cycle strobes; a push completes on the edge where
   // push && !full, a pull on the edge where pull && !empty. dout shows the head with no latency.

   logic [WIDTH-1:0] mem [ARR];
   logic [PW-1:0]    rp, wp, last;
   logic [LW-1:0]    cnt, cap;
   logic             do_push, do_pull, flush;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [PW-1:0] lim);
      return (p == lim) ? '0 : p + 1'b1;
   endfunction

`ifdef PIO_FIFO_JOIN_EN
   logic join_q;
   assign cap   = join_q ? LW'(2 * DEPTH) : LW'(DEPTH);
   assign flush = (fifo_join != join_q);
`else
   assign cap   = LW'(DEPTH);
   assign flush = 1'b0;
`endif

   assign last    = PW'(cap - LW'(1));
   assign empty   = (cnt == '0);
   assign full    = (cnt == cap);
   assign level   = cnt;
   assign dout    = empty ? '0 : mem[rp];
   assign do_push = push && !full;
   assign do_pull = pull && !empty;

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem[wp] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rp        <= '0;
         wp        <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
`ifdef PIO_FIFO_JOIN_EN
         join_q    <= fifo_join;
`endif
      end else begin
         // A rejected operation in the same cycle as clear_sticky still sets the flag.
         overflow  <= (push && full)  || (overflow  && !clear_sticky);
         underflow <= (pull && empty) || (underflow && !clear_sticky);
`ifdef PIO_FIFO_JOIN_EN
         join_q    <= fifo_join;
`endif
         if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
         end else begin
            if (do_push) wp <= ptr_inc(wp, last);
            if (do_pull) rp <= ptr_inc(rp, last);
            case ({do_push, do_pull})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end
   end

endmodule
